// File: rtl/single_port_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two requesters.
// Ports: clk_i/arstn_i; per-port a_*/b_* command handshake with tagged read
// return (rd_valid_o/rd_data_o); ram_* registered command bus and ram_data_i.
module single_port_ram_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int RAM_RD_LATENCY = 1
) (
    input  logic                      clk_i,
    input  logic                      arstn_i,

    input  logic                      a_valid_i,
    output logic                      a_ready_o,
    input  logic                      a_wr_en_i,
    input  logic [ADDR_WIDTH-1:0]     a_addr_i,
    input  logic [DATA_WIDTH-1:0]     a_data_i,
    input  logic [DATA_WIDTH/8-1:0]   a_byte_valid_i,
    output logic                      a_rd_valid_o,
    output logic [DATA_WIDTH-1:0]     a_rd_data_o,

    input  logic                      b_valid_i,
    output logic                      b_ready_o,
    input  logic                      b_wr_en_i,
    input  logic [ADDR_WIDTH-1:0]     b_addr_i,
    input  logic [DATA_WIDTH-1:0]     b_data_i,
    input  logic [DATA_WIDTH/8-1:0]   b_byte_valid_i,
    output logic                      b_rd_valid_o,
    output logic [DATA_WIDTH-1:0]     b_rd_data_o,

    output logic                      ram_wr_en_o,
    output logic [ADDR_WIDTH-1:0]     ram_addr_o,
    output logic [DATA_WIDTH-1:0]     ram_data_o,
    output logic [DATA_WIDTH/8-1:0]   ram_byte_valid_o,
    input  logic [DATA_WIDTH-1:0]     ram_data_i
);

    localparam int BYTE_VALID_WIDTH = DATA_WIDTH / 8;
    // One stage for the ram_* register plus the RAM's own read latency.
    localparam int TAG_DEPTH = 1 + RAM_RD_LATENCY;

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } pri_e;

    pri_e                        pri_q;
    logic                        grant_a;
    logic                        grant_b;
    logic                        accept;
    logic                        sel_wr;
    logic [ADDR_WIDTH-1:0]       sel_addr;
    logic [DATA_WIDTH-1:0]       sel_data;
    logic [BYTE_VALID_WIDTH-1:0] sel_be;
    logic [TAG_DEPTH-1:0]        tag_vld_q;
    logic [TAG_DEPTH-1:0]        tag_b_q;
    logic                        rsp_vld;
    logic                        rsp_b;

    // Gating with arstn_i keeps ready low while reset is held, even
    // though requesters may already be presenting commands.
    always_comb begin
        grant_a = arstn_i & a_valid_i & (~b_valid_i | (pri_q == PRI_A));
        grant_b = arstn_i & b_valid_i & (~a_valid_i | (pri_q == PRI_B));
        accept  = grant_a | grant_b;
    end

    assign a_ready_o = grant_a;
    assign b_ready_o = grant_b;

    always_comb begin
        sel_wr   = a_wr_en_i;
        sel_addr = a_addr_i;
        sel_data = a_data_i;
        sel_be   = a_byte_valid_i;
        if (grant_b) begin
            sel_wr   = b_wr_en_i;
            sel_addr = b_addr_i;
            sel_data = b_data_i;
            sel_be   = b_byte_valid_i;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            pri_q <= PRI_A;
        end else if (accept) begin
            pri_q <= grant_b ? PRI_A : PRI_B;
        end
    end

    // Idle cycles only drop wr_en; the rest of the bus holds its value.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            ram_wr_en_o      <= 1'b0;
            ram_addr_o       <= '0;
            ram_data_o       <= '0;
            ram_byte_valid_o <= '0;
        end else if (accept) begin
            ram_wr_en_o      <= sel_wr;
            ram_addr_o       <= sel_addr;
            ram_data_o       <= sel_data;
            ram_byte_valid_o <= sel_be;
        end else begin
            ram_wr_en_o      <= 1'b0;
        end
    end

    // Read tags travel alongside the RAM pipeline; the last stage lines
    // up with the cycle ram_data_i carries that read's word.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            tag_vld_q <= '0;
            tag_b_q   <= '0;
        end else begin
            tag_vld_q <= {tag_vld_q[TAG_DEPTH-2:0], accept & ~sel_wr};
            tag_b_q   <= {tag_b_q[TAG_DEPTH-2:0], grant_b};
        end
    end

    assign rsp_vld = tag_vld_q[TAG_DEPTH-1];
    assign rsp_b   = tag_b_q[TAG_DEPTH-1];

    assign a_rd_valid_o = rsp_vld & ~rsp_b;
    assign b_rd_valid_o = rsp_vld & rsp_b;
    assign a_rd_data_o  = a_rd_valid_o ? ram_data_i : '0;
    assign b_rd_data_o  = b_rd_valid_o ? ram_data_i : '0;

endmodule

// File: tb/tb_single_port_ram_arbiter.sv
// Bench for single_port_ram_arbiter: two instances (read latency 1 and 2)
// share stimulus and are checked against a transaction-level model.
module tb_single_port_ram_arbiter;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int BW = 2;

    typedef struct packed {
        logic          v;
        logic          w;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [BW-1:0] be;
    } cmd_t;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_req;
    logic ram_clr;

    logic          a_valid, a_wr, b_valid, b_wr;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_data, b_data;
    logic [BW-1:0] a_be, b_be;

    logic [1:0]    a_rdy, b_rdy, a_rv, b_rv, r_wen;
    logic [DW-1:0] a_rd [2];
    logic [DW-1:0] b_rd [2];
    logic [DW-1:0] r_data [2];
    logic [DW-1:0] r_in [2];
    logic [AW-1:0] r_addr [2];
    logic [BW-1:0] r_be [2];

    logic [DW-1:0] ram [2][256];
    logic [DW-1:0] rd0 [2];
    logic [DW-1:0] rd1 [2];

    logic [DW-1:0] mem [256];
    rsp_t          rq [4][$];
    logic          pri_a;
    logic          exp_wen;
    logic [AW-1:0] exp_waddr;
    logic [DW-1:0] exp_wdata;
    logic [BW-1:0] exp_wbe;
    logic [DW-1:0] last_rd [4];
    logic          seen_ga;
    int            cyc;
    int            nchk;
    int            nerr;

    always #5 clk = ~clk;

    single_port_ram_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_RD_LATENCY(1)
    ) u_dut0 (
        .clk_i(clk), .arstn_i(rst_n),
        .a_valid_i(a_valid), .a_ready_o(a_rdy[0]), .a_wr_en_i(a_wr),
        .a_addr_i(a_addr), .a_data_i(a_data), .a_byte_valid_i(a_be),
        .a_rd_valid_o(a_rv[0]), .a_rd_data_o(a_rd[0]),
        .b_valid_i(b_valid), .b_ready_o(b_rdy[0]), .b_wr_en_i(b_wr),
        .b_addr_i(b_addr), .b_data_i(b_data), .b_byte_valid_i(b_be),
        .b_rd_valid_o(b_rv[0]), .b_rd_data_o(b_rd[0]),
        .ram_wr_en_o(r_wen[0]), .ram_addr_o(r_addr[0]),
        .ram_data_o(r_data[0]), .ram_byte_valid_o(r_be[0]),
        .ram_data_i(r_in[0])
    );

    single_port_ram_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_RD_LATENCY(2)
    ) u_dut1 (
        .clk_i(clk), .arstn_i(rst_n),
        .a_valid_i(a_valid), .a_ready_o(a_rdy[1]), .a_wr_en_i(a_wr),
        .a_addr_i(a_addr), .a_data_i(a_data), .a_byte_valid_i(a_be),
        .a_rd_valid_o(a_rv[1]), .a_rd_data_o(a_rd[1]),
        .b_valid_i(b_valid), .b_ready_o(b_rdy[1]), .b_wr_en_i(b_wr),
        .b_addr_i(b_addr), .b_data_i(b_data), .b_byte_valid_i(b_be),
        .b_rd_valid_o(b_rv[1]), .b_rd_data_o(b_rd[1]),
        .ram_wr_en_o(r_wen[1]), .ram_addr_o(r_addr[1]),
        .ram_data_o(r_data[1]), .ram_byte_valid_o(r_be[1]),
        .ram_data_i(r_in[1])
    );

    // Read-first RAMs; instance 1 has an extra output register.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ram_clr) begin
                for (int j = 0; j < 256; j++) ram[d][j] <= '0;
            end else begin
                rd0[d] <= ram[d][r_addr[d]];
                if (r_wen[d])
                    for (int i = 0; i < BW; i++)
                        if (r_be[d][i])
                            ram[d][r_addr[d]][8*i +: 8] <= r_data[d][8*i +: 8];
            end
            rd1[d] <= rd0[d];
        end
    end

    always_comb begin
        r_in[0] = rd0[0];
        r_in[1] = rd1[1];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h",
                   tag, cyc, obs, exp);
        end
    endtask

    function automatic cmd_t wr(input int addr, input int data, input int be);
        cmd_t c;
        c.v = 1'b1; c.w = 1'b1;
        c.addr = AW'(addr); c.data = DW'(data); c.be = BW'(be);
        return c;
    endfunction

    function automatic cmd_t rd(input int addr);
        cmd_t c;
        c = '0;
        c.v = 1'b1; c.addr = AW'(addr);
        return c;
    endfunction

    function automatic cmd_t rnd_cmd();
        cmd_t c;
        c.v    = ($urandom_range(0, 9) < 6);
        c.w    = 1'($urandom_range(0, 1));
        c.addr = AW'($urandom_range(0, 15));
        c.data = DW'($urandom);
        c.be   = BW'($urandom_range(0, 3));
        return c;
    endfunction

    // One clock of stimulus, checks against the model, then model update.
    task automatic step(input cmd_t ca, input cmd_t cb);
        logic ga, gb, ev, ov;
        logic [DW-1:0] ed, od;
        cmd_t c;
        rsp_t r;
        int k;
        @(negedge clk);
        rst_n = rst_req;
        a_valid = ca.v; a_wr = ca.w; a_addr = ca.addr;
        a_data = ca.data; a_be = ca.be;
        b_valid = cb.v; b_wr = cb.w; b_addr = cb.addr;
        b_data = cb.data; b_be = cb.be;
        #1;
        if (!rst_n) begin
            for (int q = 0; q < 4; q++) rq[q].delete();
            pri_a = 1'b1;
            exp_wen = 1'b0;
        end
        ga = rst_n && ca.v && (!cb.v || pri_a);
        gb = rst_n && cb.v && (!ca.v || !pri_a);
        seen_ga = a_rdy[0];
        for (int d = 0; d < 2; d++) begin
            chk("a_ready", 32'(a_rdy[d]), 32'(ga));
            chk("b_ready", 32'(b_rdy[d]), 32'(gb));
            chk("ram_wr_en", 32'(r_wen[d]), 32'(exp_wen));
            if (exp_wen) begin
                chk("ram_addr", 32'(r_addr[d]), 32'(exp_waddr));
                chk("ram_data", 32'(r_data[d]), 32'(exp_wdata));
                chk("ram_be", 32'(r_be[d]), 32'(exp_wbe));
            end
            for (int p = 0; p < 2; p++) begin
                k = d * 2 + p;
                ev = 1'b0;
                ed = '0;
                if (rq[k].size() > 0 && rq[k][0].due == cyc) begin
                    ev = 1'b1;
                    ed = rq[k][0].data;
                    void'(rq[k].pop_front());
                end
                ov = p ? b_rv[d] : a_rv[d];
                od = p ? b_rd[d] : a_rd[d];
                if (ov === 1'b1) last_rd[k] = od;
                chk(p ? "b_rd_valid" : "a_rd_valid", 32'(ov), 32'(ev));
                chk(p ? "b_rd_data" : "a_rd_data", 32'(od), 32'(ed));
            end
        end
        exp_wen = 1'b0;
        if (ga || gb) begin
            c = ga ? ca : cb;
            if (c.w) begin
                exp_wen = 1'b1;
                exp_waddr = c.addr;
                exp_wdata = c.data;
                exp_wbe = c.be;
                for (int i = 0; i < BW; i++)
                    if (c.be[i]) mem[c.addr][8*i +: 8] = c.data[8*i +: 8];
            end else begin
                k = gb ? 1 : 0;
                r.data = mem[c.addr];
                r.due = cyc + 2;
                rq[k].push_back(r);
                r.due = cyc + 3;
                rq[2 + k].push_back(r);
            end
            pri_a = gb;
        end
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_t idle;
        idle = '0;
        nchk = 0; nerr = 0; cyc = 0;
        pri_a = 1'b1; exp_wen = 1'b0;
        exp_waddr = '0; exp_wdata = '0; exp_wbe = '0;
        for (int j = 0; j < 256; j++) mem[j] = '0;
        for (int q = 0; q < 4; q++) last_rd[q] = '0;
        rst_n = 1'b0; rst_req = 1'b0; ram_clr = 1'b1;
        a_valid = 0; a_wr = 0; a_addr = '0; a_data = '0; a_be = '0;
        b_valid = 0; b_wr = 0; b_addr = '0; b_data = '0; b_be = '0;

        // Reset held while both ports request.
        step(rd(1), rd(2));
        step(wr(1, 5, 3), rd(2));
        ram_clr = 1'b0;
        rst_req = 1'b1;

        // Both valid: strict A,B,A,B..., and A again after an even run.
        for (int i = 0; i < 7; i++) begin
            step(rd(i), rd(i + 8));
            chk("alt_grant_a", 32'(seen_ga), 32'((i % 2) == 0));
        end
        repeat (4) step(idle, idle);

        // A write then immediate read of the same word.
        for (int q = 0; q < 4; q++) last_rd[q] = '0;
        step(wr(8'h10, 16'h00A5, 2'b11), idle);
        step(rd(8'h10), idle);
        repeat (4) step(idle, idle);
        chk("wr_rd_a_lat1", 32'(last_rd[0]), 32'h00A5);
        chk("wr_rd_a_lat2", 32'(last_rd[2]), 32'h00A5);

        // Partial byte enables, then an all-zero byte-enable write.
        step(wr(8'h20, 16'h1234, 2'b11), idle);
        step(wr(8'h20, 16'hBEEF, 2'b10), idle);
        step(rd(8'h20), idle);
        step(wr(8'h20, 16'h5555, 2'b00), idle);
        repeat (4) step(idle, idle);
        chk("byte_en", 32'(last_rd[0]), 32'hBE34);
        step(rd(8'h20), idle);
        repeat (4) step(idle, idle);
        chk("be_zero_noop", 32'(last_rd[2]), 32'hBE34);

        // B back-to-back reads, ordering checked by the model.
        step(idle, wr(3, 16'h1103, 3));
        step(idle, wr(4, 16'h2204, 3));
        step(idle, rd(3));
        step(idle, rd(4));
        repeat (5) step(idle, idle);
        chk("b_b2b_last_lat2", 32'(last_rd[3]), 32'h2204);

        // Random traffic.
        for (int i = 0; i < 400; i++) step(rnd_cmd(), rnd_cmd());
        repeat (5) step(idle, idle);

        // Reset one cycle after a read is accepted drops the response.
        step(rd(8'h10), rd(8'h20));
        rst_req = 1'b0;
        step(idle, idle);
        step(rd(1), idle);
        rst_req = 1'b1;
        repeat (6) step(idle, idle);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
